mem_byte_sequencer: RTL and testbench
=====================================

# mem_byte_sequencer

Load/store sequencer between the datapath's memory stage and the byte-wide data memory. It accepts one word, halfword or byte access per request and walks it through the memory one byte per cycle in big-endian order, lowest address = most significant byte. For loads it assembles and sign- or zero-extends the result. It rejects misaligned accesses without touching memory.

## Interface
- ADDR_W, 6: byte address width of the data memory (2**ADDR_W bytes).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; transfer when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: misaligned or illegal-size request.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_re  out  1  byte read strobe.
- mem_we  out  1  byte write strobe.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; combinational, valid in the same cycle as mem_addr/mem_re.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: req_ready=1. On transfer, latch the request and compute n (byte 1, half 2, word 4).
- Transfer checks:
  - size 11 → error.
  - half with addr[0]≠0 → error.
  - word with addr[1:0]≠0 → error.
- On error, go to RESP with rsp_err=1; no memory strobe is issued.
- Otherwise go to ACCESS with byte index k=0.
- ACCESS, byte k:
  - mem_addr = base + k. Alignment guarantees no wrap past 2**ADDR_W.
  - Stores: mem_we=1, mem_wdata = byte (n-1-k) of req_wdata, so the MSB goes first.
  - Loads: mem_re=1; each mem_rdata is shifted into an accumulator (acc = {acc[23:0], mem_rdata}).
  - After byte n-1, go to RESP.
- RESP:
  - rsp_valid=1 for one cycle.
  - Loads: rsp_rdata = low 8n bits of acc, extended to 32 per req_signed.
  - Stores and errors: rsp_rdata = 0.
  - Then IDLE.
- req_ready=0 in ACCESS and RESP. New requests are taken only from IDLE; back-to-back requests are spaced by the full latency.
- mem_re and mem_we are never both high. Both are 0 outside ACCESS.

## Timing
- All outputs are registered. Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
- req_ready rises on the first clk edge after rst_n deasserts.
- Request accepted at edge T. Byte k is driven on the mem_* outputs in the cycle after edge T+k, for k=0..n-1.
- For loads, byte k's mem_rdata is sampled at edge T+k+1.
- rsp_valid is high in the cycle after edge T+n, so latency is n+1 edges from acceptance.
- req_ready returns high after edge T+n+1.
- Error requests: rsp_valid is high in the cycle after edge T+1.
- rst_n low mid-operation: all outputs go to their reset values immediately and any pending response is discarded. Bytes already written are not rolled back (partial store is permitted).

## Test plan
Memory preload: [8..11] = 80 12 34 56, [12..13] = 00 00.
- LW 8 → rsp_rdata=32'h80123456, rsp_err=0. mem_re high for exactly 4 cycles at addresses 8, 9, 10, 11. rsp_valid in the cycle after edge T+4.
- LB signed 8 → 32'hFFFFFF80. LBU 8 → 32'h00000080. LH signed 8 → 32'hFFFF8012. LHU 10 → 32'h00003456.
- SH 12, wdata 32'hABCDBEEF → mem[12]=BE, mem[13]=EF, 2 write cycles, rsp_rdata=0. A following LHU 12 → 32'h0000BEEF.
- LW 9, SH 13 and size 11 at addr 8 → each gives rsp_err=1, rsp_rdata=0, no mem_re/mem_we pulse, response in the cycle after edge T+1.
- SW 8, wdata 32'hDEADBEEF, rst_n pulsed low after the second byte → all outputs 0 at once. mem[8..9]=DE AD, mem[10..11]=34 56, no rsp_valid. req_ready=1 one edge after release.
- req_valid held high with two queued LW 8 → second accepted only after the first rsp_valid. Both return 32'h80123456, 6 edges apart.

Source files
------------

// File: rtl/mem_byte_sequencer.sv
// Byte-serial load/store sequencer: walks a byte, halfword or word access through a
// byte-wide memory MSB first (big-endian), extending load results to 32 bits.
module mem_byte_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                write_q, write_d;
  logic                signed_q, signed_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          k_q, k_d;
  logic [1:0]          last_q, last_d;
  logic [31:0]         shreg_q, shreg_d;
  logic [31:0]         acc_q, acc_d;

  logic                req_bad;
  logic [31:0]         wdata_aligned;
  logic [1:0]          req_last;
  logic [31:0]         acc_next;

  function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      2'd0:    extend = {{24{sgn & a[7]}}, a[7:0]};
      2'd1:    extend = {{16{sgn & a[15]}}, a[15:0]};
      default: extend = a;
    endcase
  endfunction

  assign req_bad = (req_size == 2'd3) ||
                   ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));

  // Store data is left-justified so the next byte to send is always shreg[31:24].
  always_comb begin
    wdata_aligned = req_wdata;
    req_last      = 2'd3;
    case (req_size)
      2'd0: begin
        wdata_aligned = {req_wdata[7:0], 24'h0};
        req_last      = 2'd0;
      end
      2'd1: begin
        wdata_aligned = {req_wdata[15:0], 16'h0};
        req_last      = 2'd1;
      end
      default: ;
    endcase
  end

  assign acc_next = {acc_q[23:0], mem_rdata};

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    write_d     = write_q;
    signed_d    = signed_q;
    size_d      = size_q;
    k_d         = k_q;
    last_d      = last_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          write_d     = req_write;
          signed_d    = req_signed;
          size_d      = req_size;
          k_d         = 2'd0;
          last_d      = req_last;
          acc_d       = 32'h0;
          if (req_bad) begin
            state_d     = RESP;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d     = ACCESS;
            mem_addr_d  = req_addr;
            mem_re_d    = ~req_write;
            mem_we_d    = req_write;
            mem_wdata_d = wdata_aligned[31:24];
            shreg_d     = {wdata_aligned[23:0], 8'h0};
          end
        end
      end
      ACCESS: begin
        if (!write_q) acc_d = acc_next;
        if (k_q == last_q) begin
          state_d     = RESP;
          mem_re_d    = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = write_q ? 32'h0 : extend(acc_next, size_q, signed_q);
        end else begin
          k_d         = k_q + 2'd1;
          mem_addr_d  = mem_addr_q + 1'b1;
          mem_wdata_d = shreg_q[31:24];
          shreg_d     = {shreg_q[23:0], 8'h0};
        end
      end
      RESP: begin
        // Error requests arrive here with rsp_valid still low and spend one extra cycle.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h0;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'd0;
      k_q         <= 2'd0;
      last_q      <= 2'd0;
      shreg_q     <= 32'h0;
      acc_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      write_q     <= write_d;
      signed_q    <= signed_d;
      size_q      <= size_d;
      k_q         <= k_d;
      last_q      <= last_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Self-checking bench for mem_byte_sequencer: directed table, multi-cycle corner
// sequences, and random traffic checked against a byte-array reference model.
module tb_mem_byte_sequencer;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0] mem      [64];
  logic [7:0] init_mem [64];
  logic [7:0] ref_mem  [64];
  logic       load_pending = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_byte_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_pending) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [5:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load();
    load_pending = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_pending = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
  endtask

  task automatic preload_plan();
    for (int i = 0; i < 64; i++) init_mem[i] = 8'h00;
    init_mem[8]  = 8'h80;
    init_mem[9]  = 8'h12;
    init_mem[10] = 8'h34;
    init_mem[11] = 8'h56;
    do_load();
  endtask

  // Reference: alignment rule, big-endian byte order, extension by plain arithmetic.
  task automatic ref_access(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [5:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
    int     n;
    longint v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    rd = 32'h0;
    er = 1'b0;
    if (sz == 2'd3 || (int'(a) % n) != 0) begin
      er = 1'b1;
      return;
    end
    v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(a) + i]);
    if (w) begin
      for (int i = 0; i < n; i++)
        ref_mem[int'(a) + i] = 8'((longint'(wd) >> (8 * (n - 1 - i))) & 255);
    end else begin
      if (sg && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      rd = 32'(v);
    end
  endtask

  // Called at a negedge; returns at the negedge after the cycle following rsp_valid.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [5:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nre, output int nwe, output int proto,
                         output logic ready_after, output logic valid_after);
    int guard;
    rd = 32'h0; er = 1'b0; lat = -1; nre = 0; nwe = 0; proto = 0;
    ready_after = 1'b0; valid_after = 1'b1;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 0; j <= 12; j++) begin
      if (mem_re || mem_we) begin
        if (mem_addr !== a + 6'(nre + nwe)) proto++;
        if (mem_re && mem_we) proto++;
        if (mem_re) nre++;
        if (mem_we) nwe++;
      end
      if (rsp_valid) begin
        lat = j;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
      if (req_ready) proto++;
      @(negedge clk);
    end
    @(negedge clk);
    ready_after = req_ready;
    valid_after = rsp_valid;
  endtask

  task automatic verify(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [5:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er, ra, va;
    int          lat, nre, nwe, proto, n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    run_req(w, sz, sg, a, wd, rd, er, lat, nre, nwe, proto, ra, va);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'(n));
    chk({tag, "_reads"}, 32'(nre), (!w && !exp_err) ? 32'(n) : 32'd0);
    chk({tag, "_writes"}, 32'(nwe), (w && !exp_err) ? 32'(n) : 32'd0);
    chk({tag, "_protocol"}, 32'(proto), 32'd0);
    chk({tag, "_ready_after"}, 32'(ra), 32'd1);
    chk({tag, "_single_pulse"}, 32'(va), 32'd0);
    $display("txn %s w=%0b size=%0d sgn=%0b addr=%0d wdata=%h rdata=%h err=%0b lat=%0d",
             tag, w, sz, sg, a, wd, rd, er, lat);
  endtask

  initial begin
    logic [31:0] erd;
    logic        eer;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [5:0]  a;
    logic [31:0] wd;
    int          accepts, nrsp, acc2, r1, r2, pulses, diff, n;
    logic        drop;
    logic [31:0] d1, d2;

    vecs[0]  = '{1'b0, 2'd2, 1'b0, 6'd8,  32'h0,        32'h80123456, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 6'd8,  32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 6'd8,  32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 6'd8,  32'h0,        32'hFFFF8012, 1'b0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 6'd10, 32'h0,        32'h00003456, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 6'd9,  32'h0,        32'h00000012, 1'b0};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 6'd12, 32'hABCDBEEF, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 6'd12, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 6'd9,  32'h0,        32'h00000000, 1'b1};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 6'd13, 32'h12345678, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 6'd8,  32'h0,        32'h00000000, 1'b1};

    // Reset state and first ready edge
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({req_ready, rsp_valid, rsp_err, mem_re, mem_we}), 32'd0);
    chk("reset_data", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    preload_plan();
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(req_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 11; i++)
      verify($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a,
             vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err);
    chk("sh12_bytes", 32'({mem[12], mem[13]}), 32'h0000BEEF);

    // Store interrupted by reset after its second byte
    req_write = 1'b1; req_size = 2'd2; req_addr = 6'd8; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sw_byte0", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 6'd8, 8'hDE}));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({req_ready, rsp_valid, rsp_err, mem_re, mem_we}), 32'd0);
    chk("midrst_data", 32'({mem_addr, mem_wdata}), 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(req_ready), 32'd0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("midrst_ready_high", 32'(req_ready), 32'd1);
      if (rsp_valid) pulses++;
    end
    chk("midrst_no_rsp", 32'(pulses), 32'd0);
    chk("midrst_partial", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEAD3456);
    $display("txn midrst_sw addr=8 wdata=deadbeef mem8_11=%h%h%h%h",
             mem[8], mem[9], mem[10], mem[11]);

    // Two queued word loads with req_valid held high
    preload_plan();
    req_write = 1'b0; req_size = 2'd2; req_addr = 6'd8; req_signed = 1'b0;
    req_valid = 1'b1;
    accepts = 0; nrsp = 0; acc2 = -1; r1 = -1; r2 = -1; drop = 1'b0;
    d1 = 32'h0; d2 = 32'h0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) begin
        if (nrsp == 0) begin r1 = c; d1 = rsp_rdata; end
        else if (nrsp == 1) begin r2 = c; d2 = rsp_rdata; end
        nrsp++;
      end
      if (drop) req_valid = 1'b0;
      else if (req_valid && req_ready) begin
        accepts++;
        if (accepts == 2) begin
          acc2 = c;
          drop = 1'b1;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(accepts), 32'd2);
    chk("b2b_responses", 32'(nrsp), 32'd2);
    chk("b2b_spacing", 32'(r2 - r1), 32'd6);
    chk("b2b_second_after_rsp", 32'(acc2 > r1), 32'd1);
    chk("b2b_rdata1", d1, 32'h80123456);
    chk("b2b_rdata2", d2, 32'h80123456);
    $display("txn b2b_lw rsp_cycles=%0d,%0d rdata=%h,%h", r1, r2, d1, d2);

    // Random traffic against the reference model
    for (int i = 0; i < 64; i++) init_mem[i] = 8'($urandom);
    do_load();
    for (int t = 0; t < 150; t++) begin
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      a  = 6'($urandom_range(0, 63));
      wd = $urandom;
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) a = a & ~6'(n - 1);
      ref_access(w, sz, sg, a, wd, erd, eer);
      verify($sformatf("rnd%0d", t), w, sz, sg, a, wd, erd, eer);
    end
    diff = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("final_mem_image", 32'(diff), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
